// File: rtl/nios_system_stream_to_onchip_writer_pkg.sv
// Shared types and constants for the stream-to-onchip-memory writer.
// Lane helpers used by the byte packer.
package stream_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOP,
    S_RECV,
    S_WRITE,
    S_DRAIN,
    S_FINISH
  } state_e;

  localparam int BYTE_LANES = 4;
  localparam int LANE_IDX_W = 2;

  // Byte lanes [idx:0] set.
  function automatic logic [BYTE_LANES-1:0] lane_mask(
    input logic [LANE_IDX_W-1:0] idx
  );
    logic [BYTE_LANES-1:0] m;
    for (int i = 0; i < BYTE_LANES; i++) begin
      m[i] = (i <= int'(idx));
    end
    return m;
  endfunction

endpackage

// File: rtl/nios_system_stream_to_onchip_writer_if.sv
// Byte stream sink plus Avalon-MM s2 write port of the memory loader.
// master = loader side, slave = source/memory side.
interface nios_system_stream_to_onchip_writer_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_startofpacket;
  logic                  in_endofpacket;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [3:0]            mem_byteenable;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [31:0]           mem_writedata;
  logic                  mem_clken;

  modport master (
    input  in_data, in_valid,
    input  in_startofpacket, in_endofpacket,
    output in_ready,
    output mem_address, mem_byteenable,
    output mem_chipselect, mem_write,
    output mem_writedata, mem_clken
  );

  modport slave (
    output in_data, in_valid,
    output in_startofpacket, in_endofpacket,
    input  in_ready,
    input  mem_address, mem_byteenable,
    input  mem_chipselect, mem_write,
    input  mem_writedata, mem_clken
  );
endinterface

// File: rtl/nios_system_stream_to_onchip_writer_packer.sv
// Little-endian byte-to-word packer: pack register, lane index, byteenable.
// Unloaded lanes stay zero so the word can be written as-is.
module byte_lane_packer
  import stream_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [7:0]            lane_byte_i,
  output logic [31:0]           data_o,
  output logic [BYTE_LANES-1:0] be_o,
  output logic                  last_lane_o
);

  logic [31:0]           data_q, data_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [LANE_IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    data_d = data_q;
    be_d   = be_q;
    idx_d  = idx_q;
    if (clear_i) begin
      data_d = '0;
      be_d   = '0;
      idx_d  = '0;
    end else if (load_i) begin
      data_d[{idx_q, 3'b000} +: 8] = lane_byte_i;
      be_d  = lane_mask(idx_q);
      idx_d = idx_q + LANE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      be_q   <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      be_q   <= be_d;
      idx_q  <= idx_d;
    end
  end

  assign data_o      = data_q;
  assign be_o        = be_q;
  assign last_lane_o = (idx_q == LANE_IDX_W'(BYTE_LANES - 1));

endmodule

// File: rtl/nios_system_stream_to_onchip_writer.sv
// Packs an Avalon-ST byte stream into 32-bit words and writes them
// to on-chip memory port s2 from a programmed word address.
module nios_system_stream_to_onchip_writer
  import stream_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  nios_system_stream_to_onchip_writer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   words_written
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic                  ovf_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  rdy_q;
  logic                  wr_q;
  logic                  eop_q;

  logic                  accept;
  logic                  sop;
  logic                  eop;
  logic                  load;
  logic                  clear;
  logic                  at_top;
  logic                  last_lane;
  logic [31:0]           pack_data;
  logic [BYTE_LANES-1:0] pack_be;

  assign accept = bus.in_valid & rdy_q;
  assign sop    = bus.in_startofpacket;
  assign eop    = bus.in_endofpacket;
  assign at_top = (addr_q == ADDR_WIDTH'(DEPTH - 1));

  assign load  = accept & (((state_q == S_WAIT_SOP) & sop)
                           | (state_q == S_RECV));
  assign clear = ((state_q == S_IDLE) & start)
               | (state_q == S_WRITE);

  byte_lane_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .clear_i     (clear),
    .lane_byte_i (bus.in_data),
    .data_o      (pack_data),
    .be_o        (pack_be),
    .last_lane_o (last_lane)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_WAIT_SOP;
            addr_q  <= start_address;
            words_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b1;
          end
        end
        S_WAIT_SOP: begin
          if (accept & sop) begin
            if (eop) begin
              state_q <= S_WRITE;
              rdy_q   <= 1'b0;
              wr_q    <= 1'b1;
              eop_q   <= 1'b1;
            end else begin
              state_q <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (accept & (eop | last_lane)) begin
            state_q <= S_WRITE;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b1;
            eop_q   <= eop;
          end
        end
        S_WRITE: begin
          wr_q    <= 1'b0;
          words_q <= words_q + (ADDR_WIDTH+1)'(1);
          // Saturate at the top word; the address never wraps to 0.
          if (!at_top) addr_q <= addr_q + ADDR_WIDTH'(1);
          if (eop_q) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else if (at_top) begin
            state_q <= S_DRAIN;
            ovf_q   <= 1'b1;
            rdy_q   <= 1'b1;
          end else begin
            state_q <= S_RECV;
            rdy_q   <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (accept & eop) begin
            state_q <= S_FINISH;
            rdy_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = rdy_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = pack_be;
  assign bus.mem_writedata  = pack_data;
  assign bus.mem_chipselect = wr_q;
  assign bus.mem_write      = wr_q;
  assign bus.mem_clken      = 1'b1;

  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_nios_system_stream_to_onchip_writer.sv
// Randomized scoreboard bench for the stream-to-onchip writer.
// Expected writes come from a packet-level model, popped by a write monitor.
module tb_nios_system_stream_to_onchip_writer;

  localparam int AW    = 13;
  localparam int DEPTH = 8192;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic          busy, done, overflow;
  logic [AW:0]   words_written;

  int  errs = 0;
  int  checks = 0;
  int  done_cnt = 0;
  bit  prev_wr = 1'b0;
  wr_t exp_q[$];
  wr_t e;

  nios_system_stream_to_onchip_writer_if #(.ADDR_WIDTH(AW)) bus();

  nios_system_stream_to_onchip_writer #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_address (start_address),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_wr && !done && !reset)
      chk("in_ready_after_write", 64'(bus.in_ready), 64'd1);
    if (bus.mem_write) begin
      chk("in_ready_in_write", 64'(bus.in_ready), 64'd0);
      chk("chipselect_in_write", 64'(bus.mem_chipselect), 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_write: addr %0h data %0h",
                 bus.mem_address, bus.mem_writedata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.mem_address), 64'(e.a));
        chk("wr_data", 64'(bus.mem_writedata), 64'(e.d));
        chk("wr_be", 64'(bus.mem_byteenable), 64'(e.be));
      end
    end
    prev_wr = bus.mem_write;
  end

  task automatic check_reset_values();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_cs", 64'(bus.mem_chipselect), 64'd0);
    chk("rst_write", 64'(bus.mem_write), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_be", 64'(bus.mem_byteenable), 64'd0);
    chk("rst_wdata", 64'(bus.mem_writedata), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    chk("rst_addr", 64'(bus.mem_address), 64'd0);
    chk("rst_clken", 64'(bus.mem_clken), 64'd1);
  endtask

  task automatic do_start(input logic [AW-1:0] addr);
    @(negedge clk);
    start = 1'b1;
    start_address = addr;
    @(negedge clk);
    start = 1'b0;
    start_address = ~addr;
    chk("ready_after_start", 64'(bus.in_ready), 64'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit sop,
                           input bit eop, input bit gaps,
                           input bit poke);
    int n;
    if (poke) begin
      start = 1'b1;
      start_address = 13'h1ABC;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ignored_start", 64'(busy), 64'd1);
    end
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.in_data = b;
    bus.in_startofpacket = sop;
    bus.in_endofpacket = eop;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errs++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket = 1'b0;
  endtask

  task automatic wait_done(input int exp_words, input bit exp_ovf);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL done_timeout: got no done expected pulse");
    end else begin
      chk("words_written", 64'(words_written), 64'(exp_words));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("writes_drained", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("words_hold", 64'(words_written), 64'(exp_words));
    end
  endtask

  // Model: word w holds bytes 4w..4w+3, only words that fit are written.
  task automatic run_packet(input logic [AW-1:0] addr,
                            input logic [7:0] pkt[$], input bit gaps,
                            input int garbage, input bit poke);
    int words, fit, nw;
    logic [31:0] d;
    logic [3:0] be;
    words = (pkt.size() + 3) / 4;
    fit = DEPTH - int'(addr);
    nw = (words < fit) ? words : fit;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      be = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < pkt.size()) begin
          d = d | (32'(pkt[4 * w + k]) << (8 * k));
          be[k] = 1'b1;
        end
      end
      exp_q.push_back('{addr + AW'(w), d, be});
    end
    do_start(addr);
    repeat (garbage)
      send_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), gaps, 1'b0);
    for (int i = 0; i < pkt.size(); i++)
      send_byte(pkt[i], i == 0, i == pkt.size() - 1, gaps,
                poke && i == 1);
    wait_done(nw, words > fit);
  endtask

  logic [7:0] pkt[$];
  int d0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    reset = 1'b0;

    pkt = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_packet(13'h0100, pkt, 1'b0, 0, 1'b0);
    run_packet(13'h0100, pkt, 1'b1, 0, 1'b1);

    pkt = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_packet(13'h0010, pkt, 1'b0, 0, 1'b0);

    pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
           8'h06, 8'h07, 8'h08, 8'h09};
    run_packet(13'h1FFF, pkt, 1'b0, 0, 1'b0);
    chk("addr_no_wrap", 64'(bus.mem_address), 64'h1FFF);

    pkt = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_packet(13'h0040, pkt, 1'b0, 3, 1'b0);

    pkt = {8'h5A};
    run_packet(13'h0002, pkt, 1'b0, 0, 1'b0);

    for (int t = 0; t < 14; t++) begin
      pkt.delete();
      repeat ($urandom_range(1, 20)) pkt.push_back(8'($urandom));
      run_packet((t % 3 == 0) ? AW'(DEPTH - $urandom_range(1, 4))
                              : AW'($urandom),
                 pkt, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)));
    end

    d0 = done_cnt;
    do_start(13'h0200);
    send_byte(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_data = 8'h03;
    bus.in_valid = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_values();
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_done_on_reset", 64'(done_cnt), 64'(d0));
    chk("no_write_on_reset", 64'(exp_q.size()), 64'd0);

    pkt = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    run_packet(13'h0300, pkt, 1'b1, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
